// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate multiplier family: FSM state type,
// operand width limits, parameter legality check and the lower-part-OR
// accumulate step used by approximate adders.
package approx_mult_pkg;

  localparam int MAX_WIDTH = 32;
  localparam int ACC_BITS  = 2 * MAX_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Legal when 2 <= w <= MAX_WIDTH and 0 <= l <= 2*w-1.
  function automatic bit approx_cols_legal(input int w, input int l);
    return (w >= 2) && (w <= MAX_WIDTH) && (l >= 0) && (l <= 2 * w - 1);
  endfunction

  // One lower-part-OR add on full-size vectors. The low l bits are a
  // carry-free OR. A single carry, the AND of the two bits in column l-1,
  // feeds the exact upper adder. Callers truncate the result to their own
  // product width. l=0 degenerates to an exact add.
  function automatic logic [ACC_BITS-1:0] approx_lower_or_add(
    input logic [ACC_BITS-1:0] acc,
    input logic [ACC_BITS-1:0] addend,
    input int unsigned         l
  );
    logic [ACC_BITS-1:0] lo_mask;
    logic [ACC_BITS-1:0] msb_mask;
    logic [ACC_BITS-1:0] hi;
    logic                c;
    if (l == 0) begin
      return acc + addend;
    end
    lo_mask  = (ACC_BITS'(1) << l) - ACC_BITS'(1);
    msb_mask = ACC_BITS'(1) << (l - 1);
    c        = |(acc & addend & msb_mask);
    hi       = (acc >> l) + (addend >> l) + ACC_BITS'(c);
    return (hi << l) | ((acc | addend) & lo_mask);
  endfunction

endpackage

// File: rtl/approx_acc_add.sv
// Combinational single accumulate step of the shift-add multiplier. This step
// selects between an exact add and a lower-part-OR approximate add over the
// low APPROX_COLS columns.
module approx_acc_add
  import approx_mult_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] addend,
  input  logic               approx,
  output logic [2*WIDTH-1:0] sum
);

  localparam int PW = 2 * WIDTH;

  // The exact add is the default. The approximate path applies only when
  // some columns are configured as approximate.
  always_comb begin
    sum = acc + addend;
    if (approx && (APPROX_COLS > 0)) begin
      sum = PW'(approx_lower_or_add(ACC_BITS'(acc), ACC_BITS'(addend),
                                    APPROX_COLS));
    end
  end

endmodule

// File: rtl/approx_seq_mult.sv
// Sequential shift-add multiplier with a per-transaction exact or approximate
// (lower-part-OR) mode, using valid/ready handshakes on input and output.
// Optional error monitor: define APPROX_SEQ_MULT_ERR_MON_EN to add the
// err_dist and err_max outputs.
module approx_seq_mult
  import approx_mult_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   inp1,
  input  logic [WIDTH-1:0]   inp2,
  input  logic               approx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
`ifdef APPROX_SEQ_MULT_ERR_MON_EN
  ,
  output logic [2*WIDTH-1:0] err_dist,
  output logic [2*WIDTH-1:0] err_max
`endif
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  generate
    if (!approx_cols_legal(WIDTH, APPROX_COLS)) begin : g_bad_cfg
      $error("approx_seq_mult: illegal WIDTH/APPROX_COLS combination");
    end
  endgenerate

  state_t          state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic            approx_reg;
  logic [PW-1:0]   acc_reg;
  logic [PW-1:0]   acc_next;
  logic [PW-1:0]   addend;
  logic [PW-1:0]   product_reg;
  logic [CW-1:0]   cnt_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;
  logic            b_bit;

  // Partial product for the current iteration: a shifted by i when b[i] is set.
  always_comb begin
    b_bit  = |(b_reg & (WIDTH'(1) << cnt_reg));
    addend = b_bit ? (PW'(a_reg) << cnt_reg) : '0;
  end

  approx_acc_add #(
    .WIDTH       (WIDTH),
    .APPROX_COLS (APPROX_COLS)
  ) u_step (
    .acc    (acc_reg),
    .addend (addend),
    .approx (approx_reg),
    .sum    (acc_next)
  );

  // Control FSM, datapath registers and registered handshake outputs. RUN runs
  // WIDTH iterations (i=0..WIDTH-1), then spends one more cycle transferring
  // the accumulator to the product register. This gives out_valid at exactly
  // WIDTH+1 cycles after the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      approx_reg    <= 1'b0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      product_reg   <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            a_reg        <= inp1;
            b_reg        <= inp2;
            approx_reg   <= approx;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          if (cnt_reg == CW'(WIDTH)) begin
            product_reg   <= acc_reg;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign product   = product_reg;

`ifdef APPROX_SEQ_MULT_ERR_MON_EN
  logic [PW-1:0] exact_prod;
  logic [PW-1:0] err_max_reg;

  // Behavioural exact reference built from the latched operands. It is meant
  // for characterisation rather than for the datapath.
  always_comb begin
    exact_prod = PW'(a_reg) * PW'(b_reg);
    err_dist   = (exact_prod >= product_reg) ? (exact_prod - product_reg)
                                             : (product_reg - exact_prod);
  end

  // Running worst-case error over transactions completed by the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_max_reg <= '0;
    end else if (out_valid_reg && out_ready && (err_dist > err_max_reg)) begin
      err_max_reg <= err_dist;
    end
  end

  assign err_max = err_max_reg;
`else
  // Error monitor compiled out: no extra ports or state.
`endif

endmodule

// File: tb/tb_approx_seq_mult.sv
// Self-checking bench for approx_seq_mult. It uses several parameterisations
// side by side, with directed tests and a randomized regression against a
// behavioural model.
module tb_approx_seq_mult;

  localparam int NCFG = 11;

  // Configuration table: (WIDTH, APPROX_COLS) per instance.
  function automatic int cfg_w(input int k);
    case (k)
      0, 1, 2, 3: return 4;
      4, 5, 6, 7: return 8;
      default:    return 16;
    endcase
  endfunction

  function automatic int cfg_l(input int k);
    case (k)
      0: return 2;   1: return 0;  2: return 3;  3: return 4;
      4: return 4;   5: return 0;  6: return 3;  7: return 8;
      8: return 0;   9: return 3;  default: return 16;
    endcase
  endfunction

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NCFG-1:0]            in_valid, in_ready, approx, out_valid, out_ready;
  logic [NCFG-1:0][31:0]      inp1, inp2;
  logic [NCFG-1:0][63:0]      product;
`ifdef APPROX_SEQ_MULT_ERR_MON_EN
  logic [NCFG-1:0][63:0]      err_dist, err_max;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
      localparam int W = cfg_w(gi);
      localparam int L = cfg_l(gi);
      logic [2*W-1:0] prod_w;
`ifdef APPROX_SEQ_MULT_ERR_MON_EN
      logic [2*W-1:0] ed_w, em_w;
      assign err_dist[gi] = 64'(ed_w);
      assign err_max[gi]  = 64'(em_w);
`endif
      approx_seq_mult #(.WIDTH(W), .APPROX_COLS(L)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[gi]),
        .in_ready  (in_ready[gi]),
        .inp1      (inp1[gi][W-1:0]),
        .inp2      (inp2[gi][W-1:0]),
        .approx    (approx[gi]),
        .out_valid (out_valid[gi]),
        .out_ready (out_ready[gi]),
        .product   (prod_w)
`ifdef APPROX_SEQ_MULT_ERR_MON_EN
        ,
        .err_dist  (ed_w),
        .err_max   (em_w)
`endif
      );
      assign product[gi] = 64'(prod_w);
    end
  endgenerate

  // Reference: the exact product, or the accumulation of the partial products
  // a*2^i for each set bit b[i]. Each partial-product addition ORs the low l
  // columns and lets a single AND carry from column l-1 into the exact upper sum.
  function automatic longint unsigned ref_mult(input int w, input int l, input bit ap,
                                               input longint unsigned a,
                                               input longint unsigned b);
    longint unsigned acc, add, modm, lom, lo, hi, c;
    modm = (64'd1 << (2 * w)) - 64'd1;
    if (!ap || l == 0) return (a * b) & modm;
    acc = 0;
    lom = (64'd1 << l) - 64'd1;
    for (int i = 0; i < w; i++) begin
      add = ((b >> i) & 64'd1) != 0 ? (a << i) : 64'd0;
      lo  = (acc | add) & lom;
      c   = (acc >> (l - 1)) & (add >> (l - 1)) & 64'd1;
      hi  = (acc >> l) + (add >> l) + c;
      acc = ((hi << l) | lo) & modm;
    end
    return acc;
  endfunction

  // Issue one transaction on instance k. The task returns the product and the
  // number of cycles from the accept edge to out_valid. ok=0 means a bounded
  // wait expired.
  task automatic do_txn(input int k, input longint unsigned a, input longint unsigned b,
                        input bit ap, output longint unsigned prod, output int lat,
                        output bit ok);
    int guard;
    ok = 1'b1;
    lat = 0;
    prod = 0;
    guard = 0;
    @(negedge clk);
    while (!in_ready[k] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready[k]) begin
      ok = 1'b0;
      return;
    end
    in_valid[k] = 1'b1;
    inp1[k]     = 32'(a);
    inp2[k]     = 32'(b);
    approx[k]   = ap;
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    inp1[k]     = $urandom;
    inp2[k]     = $urandom;
    approx[k]   = ~ap;
    while (!out_valid[k] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid[k]) ok = 1'b0;
    prod = product[k];
  endtask

  // Complete the output handshake with a single-cycle out_ready pulse.
  task automatic release_out(input int k);
    @(negedge clk);
    out_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    approx    = '0;
    inp1      = '0;
    inp2      = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NCFG; k++) begin
      total++;
      if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || product[k] !== 64'd0) begin
        bad++;
        $display("FAIL reset cfg%0d: in_ready=%b out_valid=%b product=%0d required 1/0/0",
                 k, in_ready[k], out_valid[k], product[k]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_exact_small();
    longint unsigned p;
    int lat;
    bit ok;
    do_txn(0, 3, 3, 1'b0, p, lat, ok);
    $display("txn exact_small: 3*3 product=%0d latency=%0d", p, lat);
    total++;
    if (!ok || p !== 64'd9) begin
      bad++;
      $display("FAIL exact_small product: got %0d required 9 (ok=%0b)", p, ok);
    end
    total++;
    if (lat !== 5) begin
      bad++;
      $display("FAIL exact_small latency: got %0d required 5", lat);
    end
`ifdef APPROX_SEQ_MULT_ERR_MON_EN
    total++;
    if (err_dist[0] !== 64'd0) begin
      bad++;
      $display("FAIL exact_small err_dist: got %0d required 0", err_dist[0]);
    end
`endif
    release_out(0);
  endtask

  task automatic test_approx_small();
    longint unsigned p;
    int lat;
    bit ok;
    do_txn(0, 3, 3, 1'b1, p, lat, ok);
    $display("txn approx_small: 3*3 product=%0d latency=%0d", p, lat);
    total++;
    if (!ok || p !== 64'd11) begin
      bad++;
      $display("FAIL approx_small product: got %0d required 11 (ok=%0b)", p, ok);
    end
    total++;
    if (lat !== 5) begin
      bad++;
      $display("FAIL approx_small latency: got %0d required 5", lat);
    end
`ifdef APPROX_SEQ_MULT_ERR_MON_EN
    total++;
    if (err_dist[0] !== 64'd2) begin
      bad++;
      $display("FAIL approx_small err_dist: got %0d required 2", err_dist[0]);
    end
`endif
    release_out(0);
`ifdef APPROX_SEQ_MULT_ERR_MON_EN
    total++;
    if (err_max[0] !== 64'd2) begin
      bad++;
      $display("FAIL approx_small err_max: got %0d required 2", err_max[0]);
    end
`endif
  endtask

  task automatic test_wide();
    longint unsigned p;
    int lat;
    bit ok;
    do_txn(4, 255, 255, 1'b0, p, lat, ok);
    $display("txn wide: 255*255 product=%0d latency=%0d", p, lat);
    total++;
    if (!ok || p !== 64'd65025) begin
      bad++;
      $display("FAIL wide_exact product: got %0d required 65025", p);
    end
    total++;
    if (lat !== 9) begin
      bad++;
      $display("FAIL wide_exact latency: got %0d required 9", lat);
    end
    release_out(4);
    do_txn(4, 0, 200, 1'b1, p, lat, ok);
    $display("txn wide: 0*200 approx product=%0d latency=%0d", p, lat);
    total++;
    if (!ok || p !== 64'd0) begin
      bad++;
      $display("FAIL wide_zero product: got %0d required 0", p);
    end
    release_out(4);
  endtask

  task automatic test_backpressure();
    longint unsigned p, expv;
    int lat;
    bit ok;
    expv = ref_mult(8, 4, 1'b1, 200, 123);
    do_txn(4, 200, 123, 1'b1, p, lat, ok);
    $display("txn backpressure: 200*123 approx product=%0d latency=%0d", p, lat);
    total++;
    if (!ok || p !== expv) begin
      bad++;
      $display("FAIL bp_product: got %0d required %0d", p, expv);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid[4] = c[0];
      inp1[4]     = $urandom;
      inp2[4]     = $urandom;
      total++;
      if (product[4] !== expv || out_valid[4] !== 1'b1 || in_ready[4] !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cycle %0d: product=%0d out_valid=%b in_ready=%b required %0d/1/0",
                 c, product[4], out_valid[4], in_ready[4], expv);
      end
    end
    @(negedge clk);
    in_valid[4]  = 1'b0;
    out_ready[4] = 1'b1;
    total++;
    if (in_ready[4] !== 1'b0) begin
      bad++;
      $display("FAIL bp_handshake_ready: in_ready=%b required 0", in_ready[4]);
    end
    @(posedge clk);
    #1;
    out_ready[4] = 1'b0;
    total++;
    if (out_valid[4] !== 1'b0 || in_ready[4] !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b required 0/1",
               out_valid[4], in_ready[4]);
    end
  endtask

  task automatic test_reset_in_run();
    longint unsigned p;
    int lat;
    bit ok;
    @(negedge clk);
    in_valid[4] = 1'b1;
    inp1[4]     = 32'd5;
    inp2[4]     = 32'd9;
    approx[4]   = 1'b0;
    @(posedge clk);
    #1;
    in_valid[4] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (in_ready[4] !== 1'b1 || out_valid[4] !== 1'b0 || product[4] !== 64'd0) begin
      bad++;
      $display("FAIL run_reset: in_ready=%b out_valid=%b product=%0d required 1/0/0",
               in_ready[4], out_valid[4], product[4]);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      total++;
      if (out_valid[4] !== 1'b0) begin
        bad++;
        $display("FAIL run_reset_silent cycle %0d: out_valid=%b required 0", c, out_valid[4]);
      end
    end
    do_txn(4, 6, 7, 1'b0, p, lat, ok);
    $display("txn after_reset: 6*7 product=%0d latency=%0d", p, lat);
    total++;
    if (!ok || p !== 64'd42) begin
      bad++;
      $display("FAIL after_reset product: got %0d required 42", p);
    end
    release_out(4);
  endtask

  task automatic test_random();
    longint unsigned a, b, p, expv, mask;
    int lat, w, l;
    bit ok, ap;
    for (int k = 0; k < NCFG; k++) begin
      w    = cfg_w(k);
      l    = cfg_l(k);
      mask = (64'd1 << w) - 64'd1;
      for (int n = 0; n < 200; n++) begin
        a  = longint'($urandom) & mask;
        b  = longint'($urandom) & mask;
        ap = 1'($urandom_range(0, 1));
        if (n == 0) begin
          a = mask;
          b = mask;
        end
        expv = (ap && l > 0) ? ref_mult(w, l, 1'b1, a, b) : a * b;
        do_txn(k, a, b, ap, p, lat, ok);
        $display("txn rand W=%0d L=%0d ap=%0b: %0d*%0d product=%0d latency=%0d",
                 w, l, ap, a, b, p, lat);
        total++;
        if (!ok || p !== expv || lat !== w + 1) begin
          bad++;
          $display("FAIL rand W=%0d L=%0d ap=%0b %0d*%0d: product=%0d latency=%0d required %0d/%0d",
                   w, l, ap, a, b, p, lat, expv, w + 1);
        end
        release_out(k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact_small();
    test_approx_small();
    test_wide();
    test_backpressure();
    test_reset_in_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
